uart_frame_seq: RTL and testbench

UART_FRAME_SEQ -- requirements
Module: uart_frame_seq

---
 rtl/uart_frame_seq.sv | 175 +++++++++++++++++
 tb/tb_uart_frame_seq.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_seq.sv
// uart_frame_seq: bit-period sequencer for a UART frame
// (start, 5..MAX_DATA_BITS data bits, optional parity, 1 or 2 stop bits).
// The oversample tick qualifier tick_en advances a sub-bit counter; the
// sequencer walks the frame phases and reports mid-bit and end-of-bit strobes.
//
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous, active-high reset
//   tick_en        oversample tick qualifier (one clk wide)
//   start          request a frame (sampled in IDLE only)
//   abort          terminate the current frame
//   cfg_data_bits  data bits per frame (legal 5..MAX_DATA_BITS)
//   cfg_parity_en  insert one parity bit period
//   cfg_stop2      two stop bits when set
//   busy           phase != IDLE
//   phase          0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP
//   bit_idx        index within the current phase
//   sample_stb     mid-bit strobe (combinational)
//   bit_end        last tick of a bit period (combinational)
//   done           pulse after normal frame completion
//   aborted        pulse when abort ends a frame
//   cfg_err        pulse when start is rejected for an illegal data-bit count
module uart_frame_seq #(
    parameter int unsigned OVERSAMPLE    = 16,
    parameter int unsigned MAX_DATA_BITS = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_en,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] cfg_data_bits,
    input  logic       cfg_parity_en,
    input  logic       cfg_stop2,
    output logic       busy,
    output logic [2:0] phase,
    output logic [3:0] bit_idx,
    output logic       sample_stb,
    output logic       bit_end,
    output logic       done,
    output logic       aborted,
    output logic       cfg_err
);

    localparam int unsigned SUB_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [SUB_W-1:0] SUB_MID  = SUB_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
    localparam logic [3:0]       MIN_BITS = 4'd5;
    localparam logic [3:0]       MAX_BITS = 4'(MAX_DATA_BITS);

    localparam logic [2:0] PH_IDLE   = 3'd0;
    localparam logic [2:0] PH_START  = 3'd1;
    localparam logic [2:0] PH_DATA   = 3'd2;
    localparam logic [2:0] PH_PARITY = 3'd3;
    localparam logic [2:0] PH_STOP   = 3'd4;

    logic [2:0]       r_phase,    w_phase_nxt;
    logic [SUB_W-1:0] r_sub,      w_sub_nxt;
    logic [3:0]       r_bit_idx,  w_bit_idx_nxt;
    logic [3:0]       r_cfg_bits, w_cfg_bits_nxt;
    logic             r_cfg_par,  w_cfg_par_nxt;
    logic             r_cfg_stop2, w_cfg_stop2_nxt;
    logic             r_done,     w_done_nxt;
    logic             r_aborted,  w_aborted_nxt;
    logic             r_cfg_err,  w_cfg_err_nxt;

    logic w_busy;
    logic w_tick;
    logic w_bit_end;
    logic w_cfg_legal;
    logic w_last_data;

    assign w_busy      = (r_phase != PH_IDLE);
    assign w_tick      = w_busy & tick_en;
    assign w_bit_end   = w_tick & (r_sub == SUB_LAST);
    assign w_cfg_legal = (cfg_data_bits >= MIN_BITS) && (cfg_data_bits <= MAX_BITS);
    assign w_last_data = (r_bit_idx == (r_cfg_bits - 4'd1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase     <= PH_IDLE;
            r_sub       <= '0;
            r_bit_idx   <= '0;
            r_cfg_bits  <= '0;
            r_cfg_par   <= 1'b0;
            r_cfg_stop2 <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_phase     <= w_phase_nxt;
            r_sub       <= w_sub_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_cfg_bits  <= w_cfg_bits_nxt;
            r_cfg_par   <= w_cfg_par_nxt;
            r_cfg_stop2 <= w_cfg_stop2_nxt;
            r_done      <= w_done_nxt;
            r_aborted   <= w_aborted_nxt;
            r_cfg_err   <= w_cfg_err_nxt;
        end
    end

    // Next-state and pulse logic
    always_comb begin
        w_phase_nxt     = r_phase;
        w_sub_nxt       = r_sub;
        w_bit_idx_nxt   = r_bit_idx;
        w_cfg_bits_nxt  = r_cfg_bits;
        w_cfg_par_nxt   = r_cfg_par;
        w_cfg_stop2_nxt = r_cfg_stop2;
        w_done_nxt      = 1'b0;
        w_aborted_nxt   = 1'b0;
        w_cfg_err_nxt   = 1'b0;

        if (r_phase == PH_IDLE) begin
            // abort in the same IDLE cycle cancels the request outright
            if (start && !abort) begin
                if (w_cfg_legal) begin
                    w_phase_nxt     = PH_START;
                    w_sub_nxt       = '0;
                    w_bit_idx_nxt   = '0;
                    w_cfg_bits_nxt  = cfg_data_bits;
                    w_cfg_par_nxt   = cfg_parity_en;
                    w_cfg_stop2_nxt = cfg_stop2;
                end else begin
                    w_cfg_err_nxt = 1'b1;
                end
            end
        end else if (abort) begin
            // abort wins over a coincident final bit_end
            w_phase_nxt   = PH_IDLE;
            w_sub_nxt     = '0;
            w_bit_idx_nxt = '0;
            w_aborted_nxt = 1'b1;
        end else if (tick_en) begin
            w_sub_nxt = w_bit_end ? '0 : r_sub + SUB_W'(1);
            if (w_bit_end) begin
                w_bit_idx_nxt = '0;
                case (r_phase)
                    PH_START: w_phase_nxt = PH_DATA;
                    PH_DATA: begin
                        if (!w_last_data) begin
                            w_bit_idx_nxt = r_bit_idx + 4'd1;
                        end else if (r_cfg_par) begin
                            w_phase_nxt = PH_PARITY;
                        end else begin
                            w_phase_nxt = PH_STOP;
                        end
                    end
                    PH_PARITY: w_phase_nxt = PH_STOP;
                    PH_STOP: begin
                        if (r_cfg_stop2 && (r_bit_idx == 4'd0)) begin
                            w_bit_idx_nxt = 4'd1;
                        end else begin
                            w_phase_nxt = PH_IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                    default: w_phase_nxt = PH_IDLE;
                endcase
            end
        end
    end

    assign busy       = w_busy;
    assign phase      = r_phase;
    assign bit_idx    = r_bit_idx;
    assign sample_stb = w_tick & (r_sub == SUB_MID);
    assign bit_end    = w_bit_end;
    assign done       = r_done;
    assign aborted    = r_aborted;
    assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_uart_frame_seq.sv
// Scoreboard bench for uart_frame_seq: the driver pushes the expected
// completion record for each request; the monitor accumulates per-frame
// statistics and pops/compares on every done/aborted/cfg_err pulse.
module tb_uart_frame_seq;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_en;
    logic       start;
    logic       abort;
    logic [3:0] cfg_data_bits;
    logic       cfg_parity_en;
    logic       cfg_stop2;
    logic       busy;
    logic [2:0] phase;
    logic [3:0] bit_idx;
    logic       sample_stb;
    logic       bit_end;
    logic       done;
    logic       aborted;
    logic       cfg_err;

    uart_frame_seq #(.OVERSAMPLE(OS), .MAX_DATA_BITS(9)) dut (
        .clk           (clk),
        .reset         (reset),
        .tick_en       (tick_en),
        .start         (start),
        .abort         (abort),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity_en (cfg_parity_en),
        .cfg_stop2     (cfg_stop2),
        .busy          (busy),
        .phase         (phase),
        .bit_idx       (bit_idx),
        .sample_stb    (sample_stb),
        .bit_end       (bit_end),
        .done          (done),
        .aborted       (aborted),
        .cfg_err       (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  kind;      // {cfg_err, aborted, done}
        int          ticks;
        int          s_start;
        int          s_data;
        int          s_par;
        int          s_stop;
        logic [15:0] dmask;
        logic [15:0] smask;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   tick_div = 1;
    int   tcnt = 0;

    // monitor statistics for the frame in flight
    int          m_ticks;
    int          m_sub;
    int          m_str[8];
    logic [15:0] m_dmask;
    logic [15:0] m_smask;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t frame_exp(input int n, input int p, input int s2);
        exp_t e;
        int   s;
        s         = (s2 != 0) ? 2 : 1;
        e.kind    = 3'b001;
        e.ticks   = OS * (1 + n + p + s);
        e.s_start = 1;
        e.s_data  = n;
        e.s_par   = p;
        e.s_stop  = s;
        e.dmask   = 16'((1 << n) - 1);
        e.smask   = 16'((1 << s) - 1);
        return e;
    endfunction

    function automatic exp_t abort_exp(input int ticks, input int sd, input int ss,
                                       input logic [15:0] dm, input logic [15:0] sm);
        exp_t e;
        e.kind    = 3'b010;
        e.ticks   = ticks;
        e.s_start = 1;
        e.s_data  = sd;
        e.s_par   = 0;
        e.s_stop  = ss;
        e.dmask   = dm;
        e.smask   = sm;
        return e;
    endfunction

    function automatic exp_t err_exp();
        exp_t e;
        e.kind    = 3'b100;
        e.ticks   = 0;
        e.s_start = 0;
        e.s_data  = 0;
        e.s_par   = 0;
        e.s_stop  = 0;
        e.dmask   = '0;
        e.smask   = '0;
        return e;
    endfunction

    task clr_stats();
        m_ticks = 0;
        m_sub   = 0;
        for (int i = 0; i < 8; i++) m_str[i] = 0;
        m_dmask = '0;
        m_smask = '0;
    endtask

    // tick_en generator: one tick every tick_div clocks
    initial begin
        tick_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tick_en = ((tcnt % tick_div) == 0);
            tcnt++;
        end
    end

    // monitor: sampled on the falling edge
    initial begin
        exp_t e;
        clr_stats();
        forever begin
            @(negedge clk);
            if (reset) begin
                clr_stats();
            end else begin
                if (done || aborted || cfg_err) begin
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_pulse: got done=%0b aborted=%0b cfg_err=%0b expected none (t=%0t)",
                                 done, aborted, cfg_err, $time);
                    end else begin
                        e = sb_q.pop_front();
                        chk("pulse_kind", 32'({cfg_err, aborted, done}), 32'(e.kind));
                        chk("frame_ticks", m_ticks, e.ticks);
                        chk("start_strobes", m_str[1], e.s_start);
                        chk("data_strobes", m_str[2], e.s_data);
                        chk("parity_strobes", m_str[3], e.s_par);
                        chk("stop_strobes", m_str[4], e.s_stop);
                        chk("data_idx_mask", 32'(m_dmask), 32'(e.dmask));
                        chk("stop_idx_mask", 32'(m_smask), 32'(e.smask));
                        chk("busy_at_pulse", 32'(busy), 0);
                    end
                end
                if (!busy) begin
                    chk("idle_strobes", 32'({sample_stb, bit_end}), 0);
                    clr_stats();
                end else begin
                    if (phase == 3'd2) m_dmask[bit_idx] = 1'b1;
                    if (phase == 3'd4) m_smask[bit_idx] = 1'b1;
                    if (tick_en) begin
                        chk("sample_stb", 32'(sample_stb), 32'(m_sub == OS / 2 - 1));
                        chk("bit_end", 32'(bit_end), 32'(m_sub == OS - 1));
                        if (sample_stb) m_str[phase]++;
                        m_ticks++;
                        m_sub = (m_sub + 1) % OS;
                    end else begin
                        chk("no_tick_strobes", 32'({sample_stb, bit_end}), 0);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int n, input int p, input int s2);
        cfg_data_bits = 4'(n);
        cfg_parity_en = (p != 0);
        cfg_stop2     = (s2 != 0);
    endtask

    task automatic wait_idle(input string name, input int limit);
        int k;
        k = 0;
        while (busy && k < limit) begin
            cyc();
            k++;
        end
        chk(name, 32'(busy), 0);
    endtask

    task automatic run_frame(input int n, input int p, input int s2, input int div);
        tick_div = div;
        set_cfg(n, p, s2);
        start = 1'b1;
        sb_q.push_back(frame_exp(n, p, s2));
        cyc();
        start = 1'b0;
        chk("accept_busy", 32'(busy), 1);
        chk("accept_phase", 32'(phase), 1);
        chk("accept_idx", 32'(bit_idx), 0);
        wait_idle("frame_timeout", 2000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog");
    end

    // driver
    initial begin
        int bad[4];
        int k;
        bad = '{4, 10, 0, 15};
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        set_cfg(0, 0, 0);
        #1 reset = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_phase", 32'(phase), 0);
        chk("rst_idx", 32'(bit_idx), 0);
        chk("rst_pulses", 32'({sample_stb, bit_end, done, aborted, cfg_err}), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // 8N1, start held and cfg changed while busy
        tick_div = 1;
        set_cfg(8, 0, 0);
        start = 1'b1;
        sb_q.push_back(frame_exp(8, 0, 0));
        cyc();
        chk("8n1_busy", 32'(busy), 1);
        set_cfg(5, 1, 1);
        repeat (3) cyc();
        start = 1'b0;
        wait_idle("8n1_timeout", 400);
        chk("8n1_done", 32'(done), 1);

        // 9 data, parity, 2 stop, tick every 3rd clk; starts in the done cycle
        run_frame(9, 1, 1, 3);

        // illegal data-bit counts
        tick_div = 1;
        for (int i = 0; i < 4; i++) begin
            set_cfg(bad[i], 0, 0);
            start = 1'b1;
            sb_q.push_back(err_exp());
            cyc();
            start = 1'b0;
            chk("cfgerr_pulse", 32'(cfg_err), 1);
            chk("cfgerr_busy", 32'(busy), 0);
            cyc();
            chk("cfgerr_once", 32'(cfg_err), 0);
            chk("cfgerr_idle", 32'(busy), 0);
        end
        run_frame(5, 0, 0, 1);

        // abort in DATA bit 3
        set_cfg(8, 0, 0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        k = 0;
        while (!(phase == 3'd2 && bit_idx == 4'd3) && k < 200) begin
            cyc();
            k++;
        end
        chk("reach_data3", 32'(k < 200), 1);
        abort = 1'b1;
        sb_q.push_back(abort_exp(65, 3, 0, 16'h000F, 16'h0000));
        cyc();
        abort = 1'b0;
        chk("abort_pulse", 32'(aborted), 1);
        chk("abort_nodone", 32'(done), 0);
        chk("abort_phase", 32'(phase), 0);
        run_frame(8, 0, 0, 1);

        // abort coincident with the final stop bit_end (5N1)
        set_cfg(5, 0, 0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (111) cyc();
        chk("final_phase", 32'(phase), 4);
        chk("final_bitend", 32'(bit_end), 1);
        abort = 1'b1;
        sb_q.push_back(abort_exp(112, 5, 1, 16'h001F, 16'h0001));
        cyc();
        abort = 1'b0;
        chk("coinc_aborted", 32'(aborted), 1);
        chk("coinc_nodone", 32'(done), 0);
        cyc();
        chk("coinc_nodone2", 32'(done), 0);

        // start + abort in IDLE: nothing happens, even for an illegal count
        set_cfg(8, 0, 0);
        start = 1'b1;
        abort = 1'b1;
        cyc();
        chk("idle_abort_busy", 32'(busy), 0);
        set_cfg(4, 0, 0);
        cyc();
        start = 1'b0;
        abort = 1'b0;
        chk("idle_abort_noerr", 32'(cfg_err), 0);
        chk("idle_abort_busy2", 32'(busy), 0);
        cyc();
        chk("idle_abort_noerr2", 32'(cfg_err), 0);

        // asynchronous reset mid-frame, at a bit_end
        set_cfg(8, 1, 0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (47) cyc();
        chk("pre_rst_bitend", 32'(bit_end), 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_phase", 32'(phase), 0);
        chk("arst_idx", 32'(bit_idx), 0);
        chk("arst_strobes", 32'({sample_stb, bit_end, done, aborted, cfg_err}), 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        run_frame(5, 0, 0, 1);

        repeat (3) cyc();
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
